banked_mem_arbiter: RTL
=======================

# banked_mem_arbiter

Multi-port, multi-bank on-chip data memory for the accelerator datapath. It generalises the single-requester banked memory to NUM_PORTS independent requesters, such as PE lanes and the DMA engine. Each port has a valid/ready handshake, byte-lane write enables, per-bank round-robin conflict arbitration, a one-cycle read response with an error flag, and a saturating bank-conflict counter. It sits between the compute array and the external memory-mapped bridge, and replaces direct bank-select addressing with low-order address interleaving.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 16, word-address width per port
- NUM_BANKS, 8, bank count; must be a power of two and at least 2
- NUM_PORTS, 4, requester count; at least 2
- MEM_SIZE, 16384, total words; must be a multiple of NUM_BANKS and at most 2**ADDR_WIDTH
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_PORTS  request valid, one bit per port
- req_ready  out  NUM_PORTS  request accepted this cycle; combinational from req_valid and arbitration
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  word address; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- req_be  in  NUM_PORTS*DATA_WIDTH/8  byte-lane write enables; ignored on reads
- rsp_valid  out  NUM_PORTS  read response valid
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  read data
- rsp_err  out  NUM_PORTS  out-of-range access; qualified by rsp_valid
- stat_clear  in  1  synchronous clear of conflict_count
- conflict_count  out  32  saturating count of cycles with at least one stalled in-range request

## Operation
- Bank mapping: bank = addr[log2(NUM_BANKS)-1:0]; row = addr >> log2(NUM_BANKS).
- An address is in range when addr < MEM_SIZE.
- Per-bank arbitration:
  - Each bank has a pointer rr[b] of log2(NUM_PORTS) bits, reset to 0.
  - Candidates are ports with req_valid=1, an in-range address and a matching bank.
  - The grant goes to the first candidate scanning rr[b], rr[b]+1, … modulo NUM_PORTS.
  - On a grant, rr[b] becomes (granted port + 1) mod NUM_PORTS. With no grant, rr[b] holds.
- At most one access per bank per cycle. Different banks are serviced in parallel, up to min(NUM_PORTS, NUM_BANKS) accesses per cycle.
- Out-of-range requests:
  - They skip arbitration and are always accepted (req_ready=1).
  - A write is dropped with no memory change and no response.
  - A read returns rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Handshake:
  - A transfer occurs when req_valid & req_ready.
  - A requester not granted must hold valid, write, addr, wdata and be stable until accepted.
  - req_ready=0 whenever req_valid=0.
- Writes: byte lane i is updated only when req_be[i]=1. A write with all-zero be is accepted and changes nothing.
- Responses: only accepted reads produce a response. Writes never produce one.
- Responses cannot be back-pressured. Each port has at most one response in flight.
- Conflict counter:
  - It increments when at least one port has an in-range request with req_valid=1 and req_ready=0.
  - It saturates at 0xFFFF_FFFF.
  - stat_clear has priority over increment, so that cycle loads 0.
- Reset effects:
  - Clears rr[], rsp_valid, rsp_err, rsp_rdata and conflict_count.
  - Drops any read accepted in the cycle reset is asserted; no response follows.
  - Does not clear memory contents, which power up as X. Simulation init to 0 is allowed but verification must not rely on it.

## Timing
- Read latency is 1 cycle: accepted at edge N, rsp_valid/rsp_rdata/rsp_err are registered and valid for exactly cycle N+1, then rsp_valid deasserts unless another read was accepted at N+1.
- A write accepted at edge N is visible to any read accepted at edge N+1 or later.
- A read and a write to the same word can never be accepted in the same cycle, because bank exclusivity guarantees it.
- req_ready is a same-cycle combinational output, with no registered stage.
- Reset values: req_ready=0 (all valid low), rsp_valid=0, rsp_err=0, rsp_rdata=0, conflict_count=0.
- Back-to-back accepted reads on one port give rsp_valid continuously high, one word per cycle.

## Test plan
- Parallel no-conflict:
  - Stimulus: ports 0-3 write 0x11,0x22,0x33,0x44 to addr 0,1,2,3 in one cycle, then read the same addresses.
  - Required: all req_ready=1 in both cycles; reads return the matching data one cycle later; conflict_count=0.
- Bank conflict round-robin:
  - Stimulus: ports 0-3 all read addr 8 (bank 0), held valid, from reset.
  - Required: grants in order 0,1,2,3 on consecutive cycles; conflict_count=3.
- Byte enables:
  - Stimulus: write 0xAABBCCDD to addr 5, then write 0x11223344 with be=4'b0101, then read.
  - Required: read returns 0xAA22CC44.
- Out-of-range:
  - Stimulus: read addr 16384 on port 2 while port 0 reads addr 0.
  - Required: both ready; port 2 gives rsp_err=1, rsp_rdata=0; port 0 gives rsp_err=0.
- Counter saturation and clear:
  - Stimulus: force the count to 0xFFFF_FFFE, create 3 conflict cycles, then assert stat_clear during a conflict.
  - Required: count reaches 0xFFFF_FFFF, holds there, then reads 0.
- Reset mid-operation:
  - Stimulus: assert reset in the cycle a read is accepted.
  - Required: next cycle rsp_valid=0; arbitration restarts at port 0; previously written data is still readable.

Source files
------------

// File: rtl/banked_mem_arbiter.sv
// banked_mem_arbiter
//   Multi-port, multi-bank data memory. Words are interleaved across banks on
//   the low-order address bits. Each bank grants at most one in-range request
//   per cycle using its own round-robin pointer. Out-of-range requests bypass
//   arbitration: reads return an error response, writes are dropped.
//
// Ports
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   req_valid/ready   : per-port handshake; ready is combinational
//   req_write         : 1 = write, 0 = read
//   req_addr          : per-port word address (ADDR_WIDTH bits per port)
//   req_wdata/req_be  : per-port write data and byte-lane enables
//   rsp_valid/rdata   : registered read response, one cycle after acceptance
//   rsp_err           : out-of-range read flag, qualified by rsp_valid
//   stat_clear        : clears conflict_count (wins over increment)
//   conflict_count    : saturating count of cycles with a stalled request
module banked_mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_BANKS  = 8,
   parameter int NUM_PORTS  = 4,
   parameter int MEM_SIZE   = 16384
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_PORTS-1:0]               req_valid,
   output logic [NUM_PORTS-1:0]               req_ready,
   input  logic [NUM_PORTS-1:0]               req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  req_be,
   output logic [NUM_PORTS-1:0]               rsp_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]    rsp_rdata,
   output logic [NUM_PORTS-1:0]               rsp_err,
   input  logic                               stat_clear,
   output logic [31:0]                        conflict_count
);

   localparam int BE_W      = DATA_WIDTH / 8;
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int PORT_BITS = $clog2(NUM_PORTS);
   localparam int ROWS      = MEM_SIZE / NUM_BANKS;
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

   // Storage: one array per bank, not reset.
   logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

   // Per-port address decode
   logic [BANK_BITS-1:0] port_bank [NUM_PORTS];
   logic [ROW_W-1:0]     port_row  [NUM_PORTS];
   logic [NUM_PORTS-1:0] port_in_range;

   // Arbitration results
   logic [NUM_PORTS-1:0]  grant;
   logic [PORT_BITS-1:0]  rr_q [NUM_BANKS];
   logic [PORT_BITS-1:0]  rr_d [NUM_BANKS];
   logic [NUM_BANKS-1:0]  bank_we;
   logic [ROW_W-1:0]      bank_row   [NUM_BANKS];
   logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
   logic [BE_W-1:0]       bank_be    [NUM_BANKS];

   // Response and statistics state
   logic [NUM_PORTS-1:0]            accept_rd;
   logic                            stall;
   logic [NUM_PORTS-1:0]            rsp_valid_q, rsp_valid_d;
   logic [NUM_PORTS-1:0]            rsp_err_q, rsp_err_d;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [31:0]                     conflict_count_q, conflict_count_d;

   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         port_bank[p]     = req_addr[p*ADDR_WIDTH +: BANK_BITS];
         port_row[p]      = req_addr[p*ADDR_WIDTH + BANK_BITS +: ROW_W];
         port_in_range[p] = {1'b0, req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} < MEM_LIMIT;
      end
   end

   // Per-bank round-robin: scan ports starting at rr_q[b], wrapping at
   // NUM_PORTS (which need not be a power of two).
   always_comb begin
      grant   = '0;
      bank_we = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         logic        found;
         int unsigned idx;
         rr_d[b]       = rr_q[b];
         bank_row[b]   = '0;
         bank_wdata[b] = '0;
         bank_be[b]    = '0;
         found         = 1'b0;
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_q[b]) + k;
            if (idx >= NUM_PORTS) begin
               idx = idx - NUM_PORTS;
            end
            if (!found && req_valid[idx] && port_in_range[idx] &&
                port_bank[idx] == BANK_BITS'(b)) begin
               found         = 1'b1;
               grant[idx]    = 1'b1;
               rr_d[b]       = (idx + 1 == NUM_PORTS) ? '0 : PORT_BITS'(idx + 1);
               bank_we[b]    = req_write[idx];
               bank_row[b]   = port_row[idx];
               bank_wdata[b] = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
               bank_be[b]    = req_be[idx*BE_W +: BE_W];
            end
         end
      end
   end

   always_comb begin
      req_ready = req_valid & (grant | ~port_in_range);
      stall     = |(req_valid & port_in_range & ~grant);
      accept_rd = req_valid & req_ready & ~req_write;

      rsp_valid_d = accept_rd;
      rsp_err_d   = accept_rd & ~port_in_range;
      rsp_rdata_d = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (accept_rd[p] && port_in_range[p]) begin
            rsp_rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = mem[port_bank[p]][port_row[p]];
         end
      end

      if (stat_clear) begin
         conflict_count_d = '0;
      end else if (stall && conflict_count_q != '1) begin
         conflict_count_d = conflict_count_q + 32'd1;
      end else begin
         conflict_count_d = conflict_count_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rr_q[b] <= '0;
         end
         rsp_valid_q      <= '0;
         rsp_err_q        <= '0;
         rsp_rdata_q      <= '0;
         conflict_count_q <= '0;
      end else begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rr_q[b] <= rr_d[b];
         end
         rsp_valid_q      <= rsp_valid_d;
         rsp_err_q        <= rsp_err_d;
         rsp_rdata_q      <= rsp_rdata_d;
         conflict_count_q <= conflict_count_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (bank_we[b]) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
               if (bank_be[b][i]) begin
                  mem[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
               end
            end
         end
      end
   end

   assign rsp_valid      = rsp_valid_q;
   assign rsp_err        = rsp_err_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign conflict_count = conflict_count_q;

endmodule
